// File: rtl/mc_pkg.sv
// Shared constants for the multicycle controller: state codes,
// opcode fields, long-class codes and write-data selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_ALU = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MOV_WB   = 4'd5,
    S_FETCH2   = 4'd6,
    S_FETCH3   = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [1:0] OP_ALU  = 2'b10;
  localparam logic [3:0] OP_MOV  = 4'b1100;
  localparam logic [3:0] OP_NOP  = 4'b1101;
  localparam logic [3:0] OP_RSV  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] LC_LOAD  = 2'b00;
  localparam logic [1:0] LC_STORE = 2'b01;
  localparam logic [1:0] LC_JMP   = 2'b10;
  localparam logic [1:0] LC_NOP   = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_B   = 2'b10;

endpackage

// File: rtl/mc_controller.sv
// Multicycle control FSM: fetches 1- or 3-byte instructions and
// sequences datapath loads, selects, memory and ALU controls.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit HALT_ON_RESERVED = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opCode,
  input  logic       resume,
  output logic       TRLD,
  output logic       IorD,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       IRLD,
  output logic       memWrite,
  output logic       memRead,
  output logic       wrSrc,
  output logic       DILD,
  output logic       regSrc,
  output logic       regWrite,
  output logic       pcSrc,
  output logic       ALUSrcb,
  output logic [1:0] ALUOP,
  output logic [1:0] WDSrc,
  output logic       halted,
  output logic [3:0] state_dbg
);

  logic [3:0] state;
  logic [3:0] nstate;
  logic [1:0] lcls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // IR is overwritten by byte1, so the long class is kept here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcls <= LC_NOP;
    end else if (state == S_DECODE && !opCode[3]) begin
      lcls <= opCode[1:0];
    end
  end

  always_comb begin
    nstate = S_IDLE;
    case (state)
      S_IDLE:     nstate = S_FETCH;
      S_FETCH:    nstate = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          opCode[3:2] == OP_ALU: nstate = S_EXEC_ALU;
          opCode == OP_MOV:      nstate = S_MOV_WB;
          opCode == OP_NOP:      nstate = S_FETCH;
          opCode == OP_RSV:
            nstate = HALT_ON_RESERVED ? S_HALT : S_FETCH;
          opCode == OP_HALT:     nstate = S_HALT;
          !opCode[3]:            nstate = S_FETCH2;
          default:               nstate = S_IDLE;
        endcase
      end
      S_EXEC_ALU: nstate = S_ALU_WB;
      S_ALU_WB:   nstate = S_FETCH;
      S_MOV_WB:   nstate = S_FETCH;
      S_FETCH2:   nstate = S_FETCH3;
      S_FETCH3: begin
        case (lcls)
          LC_LOAD:  nstate = S_MEM_RD;
          LC_STORE: nstate = S_MEM_WR;
          LC_JMP:   nstate = S_JUMP;
          default:  nstate = S_FETCH;
        endcase
      end
      S_MEM_RD:   nstate = S_FETCH;
      S_MEM_WR:   nstate = S_FETCH;
      S_JUMP:     nstate = S_FETCH;
      S_HALT:     nstate = resume ? S_FETCH : S_HALT;
      default:    nstate = S_IDLE;
    endcase
  end

  always_comb begin
    TRLD        = 1'b0;
    IorD        = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    IRLD        = 1'b0;
    memWrite    = 1'b0;
    memRead     = 1'b0;
    wrSrc       = 1'b0;
    DILD        = 1'b0;
    regSrc      = 1'b0;
    regWrite    = 1'b0;
    pcSrc       = 1'b0;
    ALUSrcb     = 1'b0;
    ALUOP       = 2'b00;
    WDSrc       = WD_ALU;
    halted      = 1'b0;
    case (state)
      S_FETCH: begin
        memRead = 1'b1;
        IRLD    = 1'b1;
        pcWrite = 1'b1;
      end
      S_DECODE: DILD = !opCode[3];
      S_EXEC_ALU: ALUOP = opCode[1:0];
      S_ALU_WB: begin
        regWrite = 1'b1;
        ALUOP    = opCode[1:0];
        WDSrc    = WD_ALU;
      end
      S_MOV_WB: begin
        regWrite = 1'b1;
        WDSrc    = WD_B;
      end
      S_FETCH2: begin
        memRead = 1'b1;
        IRLD    = 1'b1;
        pcWrite = 1'b1;
        regSrc  = 1'b1;
      end
      S_FETCH3: begin
        memRead = 1'b1;
        TRLD    = 1'b1;
        pcWrite = 1'b1;
        regSrc  = 1'b1;
      end
      S_MEM_RD: begin
        IorD     = 1'b1;
        memRead  = 1'b1;
        regWrite = 1'b1;
        wrSrc    = 1'b1;
        WDSrc    = WD_MEM;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        memWrite = 1'b1;
        regSrc   = 1'b1;
      end
      S_JUMP: begin
        pcWriteCond = 1'b1;
        pcSrc       = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle state and control
// vectors queued at drive time, compared on the falling edge.
module tb_mc_controller;
  import mc_pkg::*;

  typedef struct packed {
    logic       trld;
    logic       iord;
    logic       pcw;
    logic       pcwc;
    logic       irld;
    logic       memw;
    logic       memr;
    logic       wrsrc;
    logic       dild;
    logic       regsrc;
    logic       regw;
    logic       pcsrc;
    logic       alusrcb;
    logic [1:0] aluop;
    logic [1:0] wdsrc;
    logic       halted;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       ctl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opCode = 4'h0;
  logic       resume = 1'b0;
  logic       TRLD, IorD, pcWrite, pcWriteCond, IRLD, memWrite;
  logic       memRead, wrSrc, DILD, regSrc, regWrite, pcSrc, ALUSrcb;
  logic [1:0] ALUOP, WDSrc;
  logic       halted;
  logic [3:0] state_dbg;

  int n_chk = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  ctl_t got;

  mc_controller #(.HALT_ON_RESERVED(1'b0)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .resume(resume),
    .TRLD(TRLD), .IorD(IorD), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .IRLD(IRLD), .memWrite(memWrite),
    .memRead(memRead), .wrSrc(wrSrc), .DILD(DILD), .regSrc(regSrc),
    .regWrite(regWrite), .pcSrc(pcSrc), .ALUSrcb(ALUSrcb),
    .ALUOP(ALUOP), .WDSrc(WDSrc), .halted(halted),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  assign got = '{TRLD, IorD, pcWrite, pcWriteCond, IRLD, memWrite,
                 memRead, wrSrc, DILD, regSrc, regWrite, pcSrc,
                 ALUSrcb, ALUOP, WDSrc, halted};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  tag, obs, exp, $time);
  endtask

  function automatic ctl_t exp_ctl(input logic [3:0] st,
                                   input logic [3:0] op);
    ctl_t c;
    c = '0;
    case (st)
      S_FETCH:    begin c.memr = 1; c.irld = 1; c.pcw = 1; end
      S_DECODE:   c.dild = ~op[3];
      S_EXEC_ALU: c.aluop = op[1:0];
      S_ALU_WB:   begin c.regw = 1; c.aluop = op[1:0]; end
      S_MOV_WB:   begin c.regw = 1; c.wdsrc = 2'b10; end
      S_FETCH2: begin
        c.memr = 1; c.irld = 1; c.pcw = 1; c.regsrc = 1;
      end
      S_FETCH3: begin
        c.memr = 1; c.trld = 1; c.pcw = 1; c.regsrc = 1;
      end
      S_MEM_RD: begin
        c.iord = 1; c.memr = 1; c.regw = 1;
        c.wrsrc = 1; c.wdsrc = 2'b01;
      end
      S_MEM_WR:   begin c.iord = 1; c.memw = 1; c.regsrc = 1; end
      S_JUMP:     begin c.pcwc = 1; c.pcsrc = 1; end
      S_HALT:     c.halted = 1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", 32'(state_dbg), 32'(e.st));
      chk("ctl", 32'(got), 32'(e.ctl));
    end
  end

  // called just after a rising edge; covers one clock cycle
  task automatic cyc(input logic [3:0] st, input logic [3:0] op,
                     input logic rs);
    exp_t e;
    opCode = op;
    resume = rs;
    e.st = st;
    e.ctl = exp_ctl(st, op);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic long_instr(input logic [3:0] b0, input logic [3:0] b1,
                            input logic [3:0] last);
    cyc(S_FETCH, b0, 1'b0);
    cyc(S_DECODE, b0, 1'b0);
    cyc(S_FETCH2, b0, 1'b0);
    cyc(S_FETCH3, b1, 1'b0);
    if (last != S_FETCH) cyc(last, b1, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_ctl", 32'(got), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(S_IDLE, 4'h0, 1'b0);
    // ALU op 1001, resume asserted to confirm it is ignored
    cyc(S_FETCH, 4'b1001, 1'b1);
    cyc(S_DECODE, 4'b1001, 1'b1);
    cyc(S_EXEC_ALU, 4'b1001, 1'b1);
    cyc(S_ALU_WB, 4'b1001, 1'b1);
    // ALU op 1011
    cyc(S_FETCH, 4'b1011, 1'b0);
    cyc(S_DECODE, 4'b1011, 1'b0);
    cyc(S_EXEC_ALU, 4'b1011, 1'b0);
    cyc(S_ALU_WB, 4'b1011, 1'b0);
    // MOV, NOP, reserved-as-NOP
    cyc(S_FETCH, OP_MOV, 1'b0);
    cyc(S_DECODE, OP_MOV, 1'b0);
    cyc(S_MOV_WB, OP_MOV, 1'b0);
    cyc(S_FETCH, OP_NOP, 1'b0);
    cyc(S_DECODE, OP_NOP, 1'b0);
    cyc(S_FETCH, OP_RSV, 1'b0);
    cyc(S_DECODE, OP_RSV, 1'b0);
    // long class; byte1 nibble is chosen to differ from byte0 class
    long_instr(4'b0000, 4'b0001, S_MEM_RD);
    long_instr(4'b0001, 4'b0000, S_MEM_WR);
    long_instr(4'b0010, 4'b0011, S_JUMP);
    long_instr(4'b0011, 4'b0000, S_FETCH);
    long_instr(4'b0100, 4'b1111, S_MEM_RD);
    // HALT held, then resumed
    cyc(S_FETCH, OP_HALT, 1'b0);
    cyc(S_DECODE, OP_HALT, 1'b0);
    for (int i = 0; i < 10; i++) cyc(S_HALT, OP_HALT, 1'b0);
    cyc(S_HALT, OP_HALT, 1'b1);
    cyc(S_FETCH, 4'b1101, 1'b0);
    cyc(S_DECODE, 4'b1101, 1'b0);
    // reset lands on the MEM_WR cycle of a STORE
    cyc(S_FETCH, 4'b0001, 1'b0);
    cyc(S_DECODE, 4'b0001, 1'b0);
    cyc(S_FETCH2, 4'b0001, 1'b0);
    cyc(S_FETCH3, 4'b0000, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("midrst_memw", 32'(memWrite), 32'd0);
    chk("midrst_ctl", 32'(got), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_ctl", 32'(got), 32'd0);
    rst = 1'b1;
    cyc(S_IDLE, 4'h0, 1'b0);
    cyc(S_FETCH, 4'b1000, 1'b0);
    cyc(S_DECODE, 4'b1000, 1'b0);
    cyc(S_EXEC_ALU, 4'b1000, 1'b0);
    cyc(S_ALU_WB, 4'b1000, 1'b0);
    cyc(S_FETCH, 4'b1000, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
